// File: rtl/rank_select_ctrl.sv
// Masked weighted rank-order select: finds the k-th largest masked pixel of a window
// bit-serially, MSB first, time-sharing one popcount between the rank check and selection.

module bitsum_tree #(
    parameter int N  = 9,
    parameter int CW = 4
) (
    input  logic [N-1:0]  bits,
    output logic [CW-1:0] sum
);
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + {{(CW-1){1'b0}}, bits[i]};
        end
    end
endmodule

module rank_select_ctrl #(
    parameter int N  = 9,
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N*W-1:0] pixels,
    input  logic [N-1:0]   mask,
    input  logic [CW-1:0]  rank,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   result,
    output logic           err
);
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

    state_t         state;
    logic [N*W-1:0] pix_q;
    logic [N-1:0]   mask_q;
    logic [CW-1:0]  rank_q;
    logic [N-1:0]   cand;
    logic [CW-1:0]  k;
    logic [BW-1:0]  b;

    logic [W-1:0]   px;
    logic [N-1:0]   plane;
    logic [N-1:0]   ones;
    logic [N-1:0]   pc_in;
    logic [CW-1:0]  c;

    // Bit-plane b of every latched pixel, restricted to the surviving candidates.
    always_comb begin
        px    = '0;
        plane = '0;
        for (int i = 0; i < N; i++) begin
            px       = pix_q[i*W +: W];
            plane[i] = px[b];
        end
        ones  = cand & plane;
        pc_in = (state == ITER) ? ones : mask_q;
    end

    bitsum_tree #(.N(N), .CW(CW)) u_bitsum (
        .bits (pc_in),
        .sum  (c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pix_q  <= '0;
            mask_q <= '0;
            rank_q <= '0;
            cand   <= '0;
            k      <= '0;
            b      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pix_q  <= pixels;
                        mask_q <= mask;
                        rank_q <= rank;
                        result <= '0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (rank_q == '0 || rank_q > c) begin
                        err    <= 1'b1;
                        result <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cand  <= mask_q;
                        k     <= rank_q;
                        b     <= BW'(W - 1);
                        state <= ITER;
                    end
                end
                ITER: begin
                    // Enough candidates have this bit set: the answer has it too.
                    if (c >= k) begin
                        cand      <= ones;
                        result[b] <= 1'b1;
                    end else begin
                        cand      <= cand & ~ones;
                        k         <= k - c;
                        result[b] <= 1'b0;
                    end
                    if (b == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        b <= b - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rank_select_ctrl.sv
// Directed bench for rank_select_ctrl: order statistics, masks, bounds,
// ignored start while busy and asynchronous reset mid-operation.

module tb_rank_select_ctrl;
    localparam int N  = 9;
    localparam int W  = 8;
    localparam int CW = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N*W-1:0] pixels;
    logic [N-1:0]   mask;
    logic [CW-1:0]  rank;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           err;

    int tests_run = 0;
    int fails     = 0;

    rank_select_ctrl #(.N(N), .W(W), .CW(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .pixels (pixels),
        .mask   (mask),
        .rank   (rank),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] ramp();
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(10 * (i + 1));
        return r;
    endfunction

    // Drive start for one cycle (cycle 0); returns at the falling edge of cycle 1.
    task automatic issue(input logic [N*W-1:0] px, input logic [N-1:0] m, input logic [CW-1:0] r);
        @(negedge clk);
        pixels = px;
        mask   = m;
        rank   = r;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles until done, tracking busy; then look one cycle past done.
    task automatic wait_done(output int cyc, output bit busy_ok, output bit idle_ok);
        cyc     = 1;
        busy_ok = 1'b1;
        while (cyc <= 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) break;
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        idle_ok = (busy === 1'b0) && (done === 1'b0);
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({busy, done, err, result} !== '0) begin
            fails++;
            $display("FAIL reset_async: busy=%b done=%b err=%b result=%0d, required all 0", busy, done, err, result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, err, result} !== '0) begin
            fails++;
            $display("FAIL reset_release: busy=%b done=%b err=%b result=%0d, required all 0", busy, done, err, result);
        end
    endtask

    task automatic test_order_stats();
        logic [CW-1:0] ranks [3];
        logic [W-1:0]  exps  [3];
        int cyc;
        bit busy_ok, idle_ok;
        ranks = '{4'd1, 4'd5, 4'd9};
        exps  = '{8'd90, 8'd50, 8'd10};
        for (int t = 0; t < 3; t++) begin
            issue(ramp(), 9'h1FF, ranks[t]);
            wait_done(cyc, busy_ok, idle_ok);
            tests_run++;
            if (cyc != 10) begin
                fails++;
                $display("FAIL order_cycle r=%0d: done in cycle %0d, required 10", ranks[t], cyc);
            end
            tests_run++;
            if (result !== exps[t] || err !== 1'b0) begin
                fails++;
                $display("FAIL order_result r=%0d: result=%0d err=%b, required %0d err=0", ranks[t], result, err, exps[t]);
            end
            tests_run++;
            if (!busy_ok || !idle_ok) begin
                fails++;
                $display("FAIL order_busy r=%0d: busy_ok=%b idle_ok=%b, required 1 1", ranks[t], busy_ok, idle_ok);
            end
        end
    endtask

    task automatic test_single_pixel();
        int cyc;
        bit busy_ok, idle_ok;
        issue(ramp(), 9'b000000100, 4'd1);
        wait_done(cyc, busy_ok, idle_ok);
        tests_run++;
        if (cyc != 10 || result !== 8'd30 || err !== 1'b0) begin
            fails++;
            $display("FAIL single_r1: cycle=%0d result=%0d err=%b, required 10 30 0", cyc, result, err);
        end
        issue(ramp(), 9'b000000100, 4'd2);
        wait_done(cyc, busy_ok, idle_ok);
        tests_run++;
        if (cyc != 2 || result !== 8'd0 || err !== 1'b1) begin
            fails++;
            $display("FAIL single_r2_err: cycle=%0d result=%0d err=%b, required 2 0 1", cyc, result, err);
        end
        tests_run++;
        if (!busy_ok || !idle_ok) begin
            fails++;
            $display("FAIL single_err_busy: busy_ok=%b idle_ok=%b, required 1 1", busy_ok, idle_ok);
        end
    endtask

    task automatic test_dup_bounds();
        int cyc;
        bit busy_ok, idle_ok;
        issue({N*W{1'b1}}, 9'h1FF, 4'd9);
        wait_done(cyc, busy_ok, idle_ok);
        tests_run++;
        if (cyc != 10 || result !== 8'hFF || err !== 1'b0) begin
            fails++;
            $display("FAIL dup_ff_r9: cycle=%0d result=%0h err=%b, required 10 ff 0", cyc, result, err);
        end
        issue('0, 9'h1FF, 4'd3);
        wait_done(cyc, busy_ok, idle_ok);
        tests_run++;
        if (cyc != 10 || result !== 8'd0 || err !== 1'b0) begin
            fails++;
            $display("FAIL dup_zero_r3: cycle=%0d result=%0d err=%b, required 10 0 0", cyc, result, err);
        end
        issue(ramp(), 9'h1FF, 4'd0);
        wait_done(cyc, busy_ok, idle_ok);
        tests_run++;
        if (cyc != 2 || result !== 8'd0 || err !== 1'b1) begin
            fails++;
            $display("FAIL rank_zero: cycle=%0d result=%0d err=%b, required 2 0 1", cyc, result, err);
        end
    endtask

    task automatic test_sparse();
        // Pixel 0 is the rightmost field: {3,200,7,200,0,55,9,128,1} for pixels 0..8.
        // Masked-in values {3,7,0,9,1} sorted descending: 9,7,3,1,0.
        logic [N*W-1:0] px;
        logic [CW-1:0]  ranks [4];
        logic [W-1:0]   exps  [4];
        logic           eerr  [4];
        int cyc;
        bit busy_ok, idle_ok;
        px    = {8'd1, 8'd128, 8'd9, 8'd55, 8'd0, 8'd200, 8'd7, 8'd200, 8'd3};
        ranks = '{4'd1, 4'd2, 4'd5, 4'd6};
        exps  = '{8'd9, 8'd7, 8'd0, 8'd0};
        eerr  = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 4; t++) begin
            issue(px, 9'b101010101, ranks[t]);
            wait_done(cyc, busy_ok, idle_ok);
            tests_run++;
            if (result !== exps[t] || err !== eerr[t] || cyc != (eerr[t] ? 2 : 10)) begin
                fails++;
                $display("FAIL sparse r=%0d: result=%0d err=%b cycle=%0d, required %0d %b %0d",
                         ranks[t], result, err, cyc, exps[t], eerr[t], eerr[t] ? 2 : 10);
            end
        end
    endtask

    task automatic test_ignored_start();
        int cyc;
        bit busy_ok, extra_ok;
        issue(ramp(), 9'h1FF, 4'd5);
        cyc     = 1;
        busy_ok = 1'b1;
        while (cyc <= 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) break;
            if (cyc == 4) begin
                pixels = {N*W{1'b1}};
                rank   = 4'd1;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        tests_run++;
        if (cyc != 10 || result !== 8'd50 || err !== 1'b0) begin
            fails++;
            $display("FAIL ignored_result: cycle=%0d result=%0d err=%b, required 10 50 0", cyc, result, err);
        end
        tests_run++;
        if (!busy_ok) begin
            fails++;
            $display("FAIL ignored_busy: busy dropped during request, required steady 1");
        end
        extra_ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) extra_ok = 1'b0;
        end
        tests_run++;
        if (!extra_ok || result !== 8'd50) begin
            fails++;
            $display("FAIL ignored_no_service: extra_ok=%b result=%0d, required 1 50", extra_ok, result);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit busy_ok, idle_ok, quiet;
        issue(ramp(), 9'h1FF, 4'd1);
        repeat (4) @(negedge clk);
        // Cycle 5: bits 7..5 of 90 (0x5A) are resolved, lower bits still clear.
        tests_run++;
        if (busy !== 1'b1 || result !== 8'h40) begin
            fails++;
            $display("FAIL mid_progress: busy=%b result=%0h, required 1 40", busy, result);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, err, result} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b err=%b result=%0d, required all 0", busy, done, err, result);
        end
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            fails++;
            $display("FAIL mid_no_done: activity after reset, required none");
        end
        issue(ramp(), 9'h1FF, 4'd9);
        wait_done(cyc, busy_ok, idle_ok);
        tests_run++;
        if (cyc != 10 || result !== 8'd10 || err !== 1'b0 || !busy_ok || !idle_ok) begin
            fails++;
            $display("FAIL mid_fresh: cycle=%0d result=%0d err=%b busy_ok=%b idle_ok=%b, required 10 10 0 1 1",
                     cyc, result, err, busy_ok, idle_ok);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        pixels = '0;
        mask   = '0;
        rank   = '0;
        test_reset();
        test_order_stats();
        test_single_pixel();
        test_dup_bounds();
        test_sparse();
        test_ignored_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
